// File: rtl/if_pkg.sv
// if_pkg: shared fetch-stage types and constants for the instruction-fetch unit
package if_pkg;
  localparam int IF_AW = 32;
  localparam int IF_DW = 32;
  localparam logic [IF_DW-1:0] INSTR_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [IF_AW-1:0] pc;
    logic [IF_DW-1:0] instr;
  } fetch_entry_t;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} buf_state_e;
endpackage

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: circular buffer of fetch entries with EMPTY/PARTIAL/FULL occupancy FSM
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic         full_o
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  buf_state_e state_q, state_d;
  fetch_entry_t mem_q [BUF_DEPTH];
  // next occupancy and pointers; power-of-two depth lets pointers wrap naturally
  always_comb begin
    count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    rd_d    = flush_i ? '0 : rd_q + PW'(pop_i);
    wr_d    = flush_i ? '0 : wr_q + PW'(push_i);
    state_d = count_d == '0 ? EMPTY : count_d == CW'(BUF_DEPTH) ? FULL : PARTIAL;
  end
  // occupancy, pointer and state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      state_q <= EMPTY;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      state_q <= state_d;
    end
  end
  // entry storage; cleared on reset so the idle head reads as pc 0 / instr 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_q] <= din_i;
    end
  end
  assign head_o  = mem_q[rd_q];
  assign valid_o = state_q != EMPTY;
  assign full_o  = state_q == FULL;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC sequencing, redirect and valid/ready hand-off to decode (optional FETCH_PERF_CNT_EN counters)
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int                     DATA_WIDTH    = 32,
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                     BUF_DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     ifid_valid,
  input  logic                     ifid_ready,
  output logic [ADDRESS_WIDTH-1:0] ifid_pc,
  output logic [ADDRESS_WIDTH-1:0] ifid_pc_plus4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall,
  output logic [31:0]              perf_flush,
  output logic [DATA_WIDTH-1:0]    ifid_instr
`else
  output logic [DATA_WIDTH-1:0]    ifid_instr
`endif
);
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic full, deq, fetch, unused_low_bits;
  fetch_entry_t din, head;
  assign imem_addr       = {pc_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign deq             = ifid_valid & ifid_ready;
  assign fetch           = !redirect_valid & (!full | deq);
  assign din             = '{pc: imem_addr, instr: imem_instr};
  assign unused_low_bits = ^{pc_q[1:0], redirect_pc[1:0]};
  // redirect wins over sequential fetch; a stalled fetch holds the address stable
  always_comb pc_d = redirect_valid ? {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00} :
                     fetch ? pc_q + ADDRESS_WIDTH'(4) : pc_q;
  // program counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  if_fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .push_i (fetch),
    .pop_i  (deq),
    .flush_i(redirect_valid),
    .din_i  (din),
    .head_o (head),
    .valid_o(ifid_valid),
    .full_o (full)
  );
  assign ifid_pc       = head.pc;
  assign ifid_instr    = head.instr;
  assign ifid_pc_plus4 = head.pc + ADDRESS_WIDTH'(4);
`ifdef FETCH_PERF_CNT_EN
  // saturating event counters: enqueues, full stalls, redirects that discard entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (fetch && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (full && !deq && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
      if (redirect_valid && ifid_valid && perf_flush != '1) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif
endmodule
